mox125_lsu: RTL and testbench
=============================

Name: mox125_lsu

Overview:
- Load/store unit for the mox125 core: the initiator side of the data-cache request interface.
- Takes one memory operation from the execute stage (byte, halfword or word; load or store) and drives the cache's address, write data and write-enable. The cache returns read data combinationally and can stall the unit.
- Sub-word stores are done as read-modify-write, because the cache always writes 4 bytes.
- Load results are zero-extended and returned to the pipeline with a one-cycle valid pulse.

Parameters:
- AW, 32, address width of request and cache address.
- DW, 32, data width; fixed at 32, anything else unsupported.

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  pipeline request strobe.
- req_ready_o  out  1  unit can accept a request this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_addr_i  in  AW  byte address; no alignment required.
- req_wdata_i  in  DW  store data; the value sits in the low bits.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_data_o  out  DW  zero-extended load data; 0 for stores.
- resp_err_o  out  1  qualified by resp_valid_o; reserved size.
- dc_address_o  out  AW  cache byte address.
- dc_data_o  out  DW  cache write data, little-endian.
- dc_we_o  out  1  cache write enable.
- dc_data_i  in  DW  cache read data; combinational from dc_address_o, byte at address in [7:0].
- dc_stall_i  in  1  cache not ready; hold the current access.

Behaviour:
- States: IDLE, RD, WR, RSP.
- Reset value of every register is 0 and state is IDLE. A reset in any state, including mid-stall, returns to IDLE next edge; the in-flight operation is discarded and gets no response.
- dc_we_o = (state==WR) & !rst_i, so no write is ever issued during a reset cycle.

IDLE
- req_ready_o=1 only in this state; dc_we_o=0.
- On req_valid_i, latch addr, size, we and wdata. Next state:
  - size 11: RSP with err flag set.
  - word store: WR, with merged data = wdata.
  - load, or byte/half store: RD.
- No request: stay in IDLE.

RD
- dc_address_o = latched addr.
- If dc_stall_i: stay, discard dc_data_i.
- Else capture dc_data_i. Next state:
  - load: RSP, with load data masked by size: byte {24'b0, d[7:0]}, half {16'b0, d[15:0]}, word d.
  - byte store: WR, merged = {d[31:8], wdata[7:0]}.
  - half store: WR, merged = {d[31:16], wdata[15:0]}.

WR
- dc_address_o = addr, dc_data_o = merged, dc_we_o=1.
- The cache commits the write at the edge where dc_stall_i=0; next state RSP.
- While stalled, hold all outputs stable.

RSP
- resp_valid_o=1 for exactly one cycle.
- resp_data_o = load data (0 for stores and errors); resp_err_o = err flag.
- Next state IDLE.

Outputs outside the states that use them:
- resp_data_o and resp_err_o read 0 whenever resp_valid_o=0.
- dc_address_o and dc_data_o hold their last latched values.

Latency, with cycle 0 = the accept edge and no stall:
- Load: resp_valid high in cycle 2.
- Word store: resp_valid high in cycle 2.
- Byte/half store: resp_valid high in cycle 3.
- Reserved size: resp_valid high in cycle 1.
- Each stall cycle adds exactly 1.

Further rules:
- req_valid_i outside IDLE is ignored; the pipeline must hold the request until ready.
- Address arithmetic is not the unit's job: addr passes through unchanged, and any 4K wrap belongs to the cache.
- Only one operation is in flight at a time.

Test Plan:
1. Preload word 0x44332211 at 0x100, load byte at 0x101 → resp_valid in cycle 2, resp_data=0x00000022, resp_err=0, dc_we never 1.
2. Same preload, store half 0xBEEF at 0x100 → one RD cycle, then dc_we=1 for exactly one cycle with dc_data_o=0x4433BEEF at 0x100, resp in cycle 3. A following word load returns 0x4433BEEF.
3. Word load at 0x100 with dc_stall_i high for the 3 cycles after accept → data captured only after stall falls, resp_valid in cycle 5, resp_data=0x44332211, exactly one resp pulse.
4. Word store 0xDEADBEEF at 0x200 with stall high 2 cycles in WR → no RD state, dc_we high 3 cycles with stable address/data, resp in cycle 4. Readback gives 0xDEADBEEF.
5. Request with size=11 → resp_valid in cycle 1, resp_err=1, resp_data=0, dc_we never asserted; req_ready high again in cycle 2.
6. Sub-word store held in WR by stall, assert rst_i one cycle → dc_we=0 in the reset cycle, IDLE and req_ready=1 next cycle, no resp_valid ever produced. A subsequent load completes normally.

Source files
------------

// File: rtl/mox125_lsu.sv
// mox125 load/store unit: drives the data-cache request interface for one
// byte/half/word access at a time; sub-word stores are read-modify-write.
module mox125_lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          resp_valid_o,
    output logic [DW-1:0] resp_data_o,
    output logic          resp_err_o,
    output logic [AW-1:0] dc_address_o,
    output logic [DW-1:0] dc_data_o,
    output logic          dc_we_o,
    input  logic [DW-1:0] dc_data_i,
    input  logic          dc_stall_i,
    output logic [1:0]    dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid_i and
    // req_ready_o are both high; the requester holds it stable until then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          we_q;
    logic [15:0]   wdata_q;
    logic [DW-1:0] merged_q;
    logic [DW-1:0] load_q;
    logic          err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            merged_q <= '0;
            load_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        size_q  <= req_size_i;
                        we_q    <= req_we_i;
                        wdata_q <= req_wdata_i[15:0];
                        load_q  <= '0;
                        err_q   <= (req_size_i == 2'b11);
                        if (req_size_i == 2'b11) begin
                            state <= RSP;
                        end else if (req_we_i && req_size_i == 2'b10) begin
                            merged_q <= req_wdata_i;
                            state    <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    // Read data is only trusted on a non-stalled cycle.
                    if (!dc_stall_i) begin
                        if (!we_q) begin
                            case (size_q)
                                2'b00:   load_q <= {{(DW-8){1'b0}}, dc_data_i[7:0]};
                                2'b01:   load_q <= {{(DW-16){1'b0}}, dc_data_i[15:0]};
                                default: load_q <= dc_data_i;
                            endcase
                            state <= RSP;
                        end else begin
                            if (size_q == 2'b00)
                                merged_q <= {dc_data_i[DW-1:8], wdata_q[7:0]};
                            else
                                merged_q <= {dc_data_i[DW-1:16], wdata_q[15:0]};
                            state <= WR;
                        end
                    end
                end
                WR: begin
                    if (!dc_stall_i) state <= RSP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == RSP);
    assign resp_data_o  = (state == RSP) ? load_q : '0;
    assign resp_err_o   = (state == RSP) & err_q;
    assign dc_address_o = addr_q;
    assign dc_data_o    = merged_q;
    // Gate with reset so a reset landing on a stalled write never commits it.
    assign dc_we_o      = (state == WR) & ~rst_i;
    assign dbg_state    = state;

endmodule

// File: tb/tb_mox125_lsu.sv
// Bench for mox125_lsu: byte-array cache model, directed test-plan scenarios
// and randomized operations checked against a byte-level memory model.
module tb_mox125_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] dc_address;
  logic [31:0] dc_data_o;
  logic        dc_we;
  logic [31:0] dc_data_i;
  logic        dc_stall = 1'b0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  mox125_lsu #(.AW(32), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_size_i(req_size),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_err_o(resp_err),
    .dc_address_o(dc_address), .dc_data_o(dc_data_o), .dc_we_o(dc_we),
    .dc_data_i(dc_data_i), .dc_stall_i(dc_stall), .dbg_state(dbg_state)
  );

  // cache model: 4K bytes, wraps on the low 12 address bits
  logic [7:0]  cmem [0:4095];
  logic        clr = 1'b1;
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_word = '0;
  logic [11:0] a0, a1, a2, a3;
  assign a0 = dc_address[11:0];
  assign a1 = a0 + 12'd1;
  assign a2 = a0 + 12'd2;
  assign a3 = a0 + 12'd3;
  assign dc_data_i = {cmem[a3], cmem[a2], cmem[a1], cmem[a0]};

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) cmem[i] <= 8'h00;
    end else if (pre_en) begin
      cmem[pre_addr]          <= pre_word[7:0];
      cmem[pre_addr + 12'd1]  <= pre_word[15:8];
      cmem[pre_addr + 12'd2]  <= pre_word[23:16];
      cmem[pre_addr + 12'd3]  <= pre_word[31:24];
    end else if (dc_we && !dc_stall) begin
      cmem[a0] <= dc_data_o[7:0];
      cmem[a1] <= dc_data_o[15:8];
      cmem[a2] <= dc_data_o[23:16];
      cmem[a3] <= dc_data_o[31:24];
    end
  end

  // reference model: what memory holds, byte by byte
  logic [7:0] ref_mem [0:4095];

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [11:0] b;
    logic [31:0] w;
    b = addr[11:0];
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[b + 12'(i)];
    return w;
  endfunction

  task automatic ref_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] data, output logic err);
    int nb;
    logic [11:0] b;
    data = '0;
    err = (size == 2'b11);
    b = addr[11:0];
    if (!err) begin
      nb = 1 << size;
      for (int i = 0; i < nb; i++) begin
        if (we) ref_mem[b + 12'(i)] = wdata[8*i +: 8];
        else data[8*i +: 8] = ref_mem[b + 12'(i)];
      end
    end
  endtask

  // driver tasks
  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    for (int i = 0; i < 4; i++) ref_mem[addr[11:0] + 12'(i)] = word[8*i +: 8];
    pre_addr = addr[11:0];
    pre_word = word;
    pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issue one request at a negedge in IDLE; stall is held high for cycles 1..nstall.
  task automatic run_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int nstall,
                        output logic accepted, output int resp_cyc, output int resp_cnt,
                        output logic [31:0] rdata, output logic err, output int ready_cyc,
                        output int we_cnt, output logic [31:0] wr_addr,
                        output logic [31:0] wr_data, output logic wr_stable);
    logic [31:0] junk;
    resp_cyc = -1; resp_cnt = 0; rdata = '0; err = 1'b0; ready_cyc = -1;
    we_cnt = 0; wr_addr = '0; wr_data = '0; wr_stable = 1'b1;
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    dc_stall = 1'b0;
    #1 accepted = req_ready;
    @(negedge clk);
    junk = $urandom;
    req_valid = 1'b0; req_addr = junk; req_wdata = ~junk; req_we = junk[0]; req_size = junk[2:1];
    for (int n = 1; n <= 12; n++) begin
      dc_stall = (n <= nstall);
      #1;
      if (dc_we) begin
        if (we_cnt == 0) begin
          wr_addr = dc_address; wr_data = dc_data_o;
        end else if (dc_address !== wr_addr || dc_data_o !== wr_data) begin
          wr_stable = 1'b0;
        end
        we_cnt++;
      end
      if (resp_valid) begin
        resp_cnt++;
        if (resp_cyc < 0) begin resp_cyc = n; rdata = resp_data; err = resp_err; end
      end
      if (req_ready && ready_cyc < 0) ready_cyc = n;
      @(negedge clk);
    end
    dc_stall = 1'b0;
  endtask

  // scenarios
  task automatic test_reset;
    rst = 1'b1; clr = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (dc_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", dc_we); end
    @(negedge clk);
    clr = 1'b0; rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_data !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got v=%b e=%b d=%h want 0/0/0", resp_valid, resp_err, resp_data); end
    checks++; if (dc_address !== 32'h0 || dc_data_o !== 32'h0) begin
      errors++; $display("FAIL reset_dc: got a=%h d=%h want 0/0", dc_address, dc_data_o); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
  endtask

  task automatic test_load_byte;
    logic acc, err, st; int rc, rn, yc, wc; logic [31:0] rd, wa, wd;
    preload(32'h100, 32'h44332211);
    run_op(1'b0, 2'b00, 32'h101, 32'h0, 0, acc, rc, rn, rd, err, yc, wc, wa, wd, st);
    checks++; if (rc !== 2) begin errors++; $display("FAIL tp1_latency: got %0d want 2", rc); end
    checks++; if (rd !== 32'h00000022) begin errors++; $display("FAIL tp1_data: got %h want 00000022", rd); end
    checks++; if (err !== 1'b0 || wc !== 0) begin errors++; $display("FAIL tp1_err_we: got err=%b we=%0d want 0/0", err, wc); end
  endtask

  task automatic test_store_half;
    logic acc, err, st; int rc, rn, yc, wc; logic [31:0] rd, wa, wd;
    run_op(1'b1, 2'b01, 32'h100, 32'h1234BEEF, 0, acc, rc, rn, rd, err, yc, wc, wa, wd, st);
    checks++; if (rc !== 3) begin errors++; $display("FAIL tp2_latency: got %0d want 3", rc); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL tp2_we_cycles: got %0d want 1", wc); end
    checks++; if (wa !== 32'h100 || wd !== 32'h4433BEEF) begin
      errors++; $display("FAIL tp2_write: got a=%h d=%h want 100/4433beef", wa, wd); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tp2_resp_data: got %h want 0", rd); end
    void'(ref_word(32'h0));
    for (int i = 0; i < 2; i++) ref_mem[12'h100 + 12'(i)] = (i == 0) ? 8'hEF : 8'hBE;
    run_op(1'b0, 2'b10, 32'h100, 32'h0, 0, acc, rc, rn, rd, err, yc, wc, wa, wd, st);
    checks++; if (rd !== 32'h4433BEEF) begin errors++; $display("FAIL tp2_readback: got %h want 4433beef", rd); end
  endtask

  task automatic test_load_stall;
    logic acc, err, st; int rc, rn, yc, wc; logic [31:0] rd, wa, wd;
    preload(32'h100, 32'h44332211);
    run_op(1'b0, 2'b10, 32'h100, 32'h0, 3, acc, rc, rn, rd, err, yc, wc, wa, wd, st);
    checks++; if (rc !== 5) begin errors++; $display("FAIL tp3_latency: got %0d want 5", rc); end
    checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL tp3_data: got %h want 44332211", rd); end
    checks++; if (rn !== 1) begin errors++; $display("FAIL tp3_pulses: got %0d want 1", rn); end
  endtask

  task automatic test_store_word_stall;
    logic acc, err, st; int rc, rn, yc, wc; logic [31:0] rd, wa, wd;
    run_op(1'b1, 2'b10, 32'h200, 32'hDEADBEEF, 2, acc, rc, rn, rd, err, yc, wc, wa, wd, st);
    void'(ref_word(32'h0));
    for (int i = 0; i < 4; i++) ref_mem[12'h200 + 12'(i)] = 8'(32'hDEADBEEF >> (8*i));
    checks++; if (rc !== 4) begin errors++; $display("FAIL tp4_latency: got %0d want 4", rc); end
    checks++; if (wc !== 3 || st !== 1'b1) begin errors++; $display("FAIL tp4_we: got cycles=%0d stable=%b want 3/1", wc, st); end
    checks++; if (wa !== 32'h200 || wd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL tp4_write: got a=%h d=%h want 200/deadbeef", wa, wd); end
    run_op(1'b0, 2'b10, 32'h200, 32'h0, 0, acc, rc, rn, rd, err, yc, wc, wa, wd, st);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL tp4_readback: got %h want deadbeef", rd); end
  endtask

  task automatic test_reserved;
    logic acc, err, st; int rc, rn, yc, wc; logic [31:0] rd, wa, wd;
    run_op(1'b1, 2'b11, 32'h300, 32'hFFFFFFFF, 0, acc, rc, rn, rd, err, yc, wc, wa, wd, st);
    checks++; if (rc !== 1) begin errors++; $display("FAIL tp5_latency: got %0d want 1", rc); end
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL tp5_resp: got err=%b d=%h want 1/0", err, rd); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL tp5_we: got %0d want 0", wc); end
    checks++; if (yc !== 2) begin errors++; $display("FAIL tp5_ready: got cycle %0d want 2", yc); end
  endtask

  task automatic test_reset_mid_store;
    logic acc, err, st; int rc, rn, yc, wc, pulses; logic [31:0] rd, wa, wd;
    preload(32'h180, 32'h44332211);
    pulses = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h181; req_wdata = 32'h55;
    @(negedge clk);                      // cycle 1: RD, not stalled
    req_valid = 1'b0;
    #1 if (resp_valid) pulses++;
    @(negedge clk);                      // cycle 2: WR, stalled
    dc_stall = 1'b1;
    #1;
    checks++; if (dc_we !== 1'b1) begin errors++; $display("FAIL tp6_in_wr: got we=%b want 1", dc_we); end
    if (resp_valid) pulses++;
    @(negedge clk);                      // cycle 3: reset while stalled in WR
    rst = 1'b1;
    #1;
    checks++; if (dc_we !== 1'b0) begin errors++; $display("FAIL tp6_reset_we: got %b want 0", dc_we); end
    if (resp_valid) pulses++;
    @(negedge clk);
    rst = 1'b0; dc_stall = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL tp6_idle: got ready=%b state=%0d want 1/0", req_ready, dbg_state); end
    for (int n = 0; n < 4; n++) begin
      if (resp_valid) pulses++;
      @(negedge clk);
      #1;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL tp6_no_resp: got %0d pulses want 0", pulses); end
    @(negedge clk);
    run_op(1'b0, 2'b10, 32'h180, 32'h0, 0, acc, rc, rn, rd, err, yc, wc, wa, wd, st);
    checks++; if (rc !== 2 || rd !== 32'h44332211) begin
      errors++; $display("FAIL tp6_after: got cyc=%0d d=%h want 2/44332211", rc, rd); end
  endtask

  task automatic test_random;
    logic acc, err, st, we, exp_err; int rc, rn, yc, wc, ns, exp_lat, exp_wc, r;
    logic [1:0] size; logic [31:0] base, addr, wdata, rd, wa, wd, exp_d;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      size = (r == 9) ? 2'b11 : 2'(r % 3);
      we = 1'($urandom_range(0, 1));
      base = $urandom;
      addr = {base[31:12], 7'b0011000, base[4:0]};
      wdata = $urandom;
      ns = $urandom_range(0, 3);
      run_op(we, size, addr, wdata, ns, acc, rc, rn, rd, err, yc, wc, wa, wd, st);
      ref_op(we, size, addr, wdata, exp_d, exp_err);
      exp_lat = (size == 2'b11) ? 1 : ((we && size != 2'b10) ? 3 + ns : 2 + ns);
      exp_wc  = (size == 2'b11 || !we) ? 0 : ((size == 2'b10) ? 1 + ns : 1);
      checks++; if (acc !== 1'b1 || rc !== exp_lat || rn !== 1 || yc !== exp_lat + 1) begin
        errors++; $display("FAIL rnd_timing[%0d]: got acc=%b lat=%0d pulses=%0d ready=%0d want 1/%0d/1/%0d",
                           k, acc, rc, rn, yc, exp_lat, exp_lat + 1); end
      checks++; if (rd !== exp_d || err !== exp_err) begin
        errors++; $display("FAIL rnd_resp[%0d]: got d=%h err=%b want d=%h err=%b", k, rd, err, exp_d, exp_err); end
      checks++; if (wc !== exp_wc || st !== 1'b1) begin
        errors++; $display("FAIL rnd_we[%0d]: got cycles=%0d stable=%b want %0d/1", k, wc, st, exp_wc); end
      if (exp_wc > 0) begin
        checks++; if (wa !== addr || wd !== ref_word(addr)) begin
          errors++; $display("FAIL rnd_write[%0d]: got a=%h d=%h want a=%h d=%h", k, wa, wd, addr, ref_word(addr)); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_load_byte();
    test_store_half();
    test_load_stall();
    test_store_word_stall();
    test_reserved();
    test_reset_mid_store();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
